// File: rtl/sram_controller.sv
// Splits one 32-bit MEM-stage access into two 16-bit SRAM accesses (low half, then high half).
// Latency 2*WAIT_CYCLES+1 cycles; ready is held low to stall the pipeline until DONE.
module sram_controller #(
   parameter int WAIT_CYCLES = 2,
   parameter int BASE_ADDR   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        SRAM_WE_N,
   output logic [17:0] SRAM_ADDR,
   inout  wire  [15:0] SRAM_DQ
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [16:0]   wa_q, wa_d;
   logic [31:0]   wdat_q, wdat_d;
   logic          wr_q, wr_d;
   logic [31:0]   rdat_q, rdat_d;
   logic          req;
   logic          last;
   logic          dq_oe;
   logic [15:0]   dq_out;

   assign req  = wr_en | rd_en;
   assign last = (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wa_q    <= '0;
         wdat_q  <= '0;
         wr_q    <= 1'b0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wa_q    <= wa_d;
         wdat_q  <= wdat_d;
         wr_q    <= wr_d;
         rdat_q  <= rdat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wa_d    = wa_q;
      wdat_d  = wdat_q;
      wr_d    = wr_q;
      rdat_d  = rdat_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = LO;
               cnt_d   = '0;
               wa_d    = 17'((address - 32'(BASE_ADDR)) >> 2);
               wdat_d  = write_data;
               wr_d    = wr_en;
            end
         end
         LO: begin
            if (last) begin
               state_d = HI;
               cnt_d   = '0;
               if (!wr_q) rdat_d[15:0] = SRAM_DQ;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HI: begin
            if (last) begin
               state_d = DONE;
               cnt_d   = '0;
               if (!wr_q) rdat_d[31:16] = SRAM_DQ;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      SRAM_WE_N = 1'b1;
      SRAM_ADDR = '0;
      dq_oe     = 1'b0;
      dq_out    = '0;
      ready     = 1'b0;
      case (state_q)
         IDLE: ready = ~req;
         LO: begin
            SRAM_ADDR = {wa_q, 1'b0};
            SRAM_WE_N = ~wr_q;
            dq_oe     = wr_q;
            dq_out    = wdat_q[15:0];
         end
         HI: begin
            SRAM_ADDR = {wa_q, 1'b1};
            SRAM_WE_N = ~wr_q;
            dq_oe     = wr_q;
            dq_out    = wdat_q[31:16];
         end
         default: ready = 1'b1;
      endcase
   end

   assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
   assign read_data = rdat_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (WAIT_CYCLES 2 and 1), each with a behavioural SRAM,
// and a queue of expected (stall length, read_data) pairs checked whenever ready returns high.
module tb_sram_controller;

   typedef struct {
      int          stall;
      logic [31:0] rd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en, rd_en;
   logic [31:0] address, write_data;
   wire  [31:0] read_data;
   wire         ready, we_n;
   wire  [17:0] sa;
   wire  [15:0] dq;

   logic        wr_en1, rd_en1;
   logic [31:0] address1, write_data1;
   wire  [31:0] read_data1;
   wire         ready1, we_n1;
   wire  [17:0] sa1;
   wire  [15:0] dq1;

   logic        sram_oe;
   logic        pl_en, pl_sel;
   logic [17:0] pl_idx;
   logic [15:0] pl_val;
   logic [15:0] m0 [0:262143];
   logic [15:0] m1 [0:262143];
   logic [17:0] trace [0:15];

   exp_t q0[$], q1[$];
   exp_t e0, e1;
   int   checks = 0, errors = 0;
   int   st0 = 0, st1 = 0;

   always #5 clk = ~clk;

   sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(1024)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready),
      .SRAM_WE_N(we_n), .SRAM_ADDR(sa), .SRAM_DQ(dq));

   sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(1024)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address1),
      .write_data(write_data1), .read_data(read_data1), .ready(ready1),
      .SRAM_WE_N(we_n1), .SRAM_ADDR(sa1), .SRAM_DQ(dq1));

   // Behavioural SRAMs: write on rising edges with WE_N low, drive the bus otherwise.
   always @(posedge clk) begin
      if (pl_en && !pl_sel) m0[pl_idx] <= pl_val;
      else if (!we_n) m0[sa] <= dq;
   end
   always @(posedge clk) begin
      if (pl_en && pl_sel) m1[pl_idx] <= pl_val;
      else if (!we_n1) m1[sa1] <= dq1;
   end
   assign dq  = (sram_oe && we_n)  ? m0[sa]  : 16'hzzzz;
   assign dq1 = (sram_oe && we_n1) ? m1[sa1] : 16'hzzzz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) st0 = 0;
      else if (!ready) st0++;
      else if (st0 > 0) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL done0_unexpected: got completion expected none");
         end else begin
            e0 = q0.pop_front();
            chk("stall0", 32'(st0), 32'(e0.stall));
            chk("rdata0", read_data, e0.rd);
         end
         st0 = 0;
      end
   end

   always @(negedge clk) begin
      if (!rst) st1 = 0;
      else if (!ready1) st1++;
      else if (st1 > 0) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL done1_unexpected: got completion expected none");
         end else begin
            e1 = q1.pop_front();
            chk("stall1", 32'(st1), 32'(e1.stall));
            chk("rdata1", read_data1, e1.rd);
         end
         st1 = 0;
      end
   end

   task automatic preload(input bit sel, input int idx, input logic [15:0] v);
      @(posedge clk); #1;
      pl_en = 1'b1; pl_sel = sel; pl_idx = 18'(idx); pl_val = v;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   // hold=1 keeps the enables up until DONE; hold=0 drops them after the latching edge.
   task automatic xact(input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [31:0] data, input bit hold);
      @(posedge clk); #1;
      wr_en = wr; rd_en = rd; address = addr; write_data = data;
      if (!hold) begin
         @(posedge clk); #1;
         wr_en = 1'b0; rd_en = 1'b0; address = '1; write_data = '0;
      end
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         trace[k] = sa;
         if (ready) break;
      end
      if (!ready) begin
         checks++; errors++;
         $display("FAIL xact_timeout: got ready=0 expected ready=1 within 12 cycles");
      end
      if (hold) begin
         @(posedge clk); #1;
         wr_en = 1'b0; rd_en = 1'b0;
      end
   endtask

   initial begin
      int n;
      rst = 1'b0; sram_oe = 1'b0;
      wr_en = 0; rd_en = 0; address = '0; write_data = '0;
      wr_en1 = 0; rd_en1 = 0; address1 = '0; write_data1 = '0;
      pl_en = 0; pl_sel = 0; pl_idx = '0; pl_val = '0;

      #12;
      chk("rst_ready", {31'b0, ready}, 32'd1);
      chk("rst_we_n", {31'b0, we_n}, 32'd1);
      chk("rst_addr", {14'b0, sa}, 32'd0);
      chk("rst_rdata", read_data, 32'd0);
      chk("rst_dq_z", {31'b0, dq === 16'hzzzz}, 32'd1);
      wr_en = 1'b1; #1;
      chk("rst_ready_en", {31'b0, ready}, 32'd0);
      wr_en = 1'b0;
      @(negedge clk);
      rst = 1'b1; sram_oe = 1'b1;

      q0.push_back('{5, 32'h0000_0000});
      xact(1, 0, 32'd1024, 32'hDEAD_BEEF, 1);
      chk("wr_lo", {16'b0, m0[0]}, 32'h0000_BEEF);
      chk("wr_hi", {16'b0, m0[1]}, 32'h0000_DEAD);

      q0.push_back('{5, 32'hDEAD_BEEF});
      xact(0, 1, 32'd1024, 32'h0, 1);

      preload(0, 2, 16'h5678);
      preload(0, 3, 16'h1234);
      q0.push_back('{5, 32'h1234_5678});
      xact(0, 1, 32'd1031, 32'h0, 1);
      chk("map_lo_addr", {14'b0, trace[1]}, 32'd2);
      chk("map_lo_addr2", {14'b0, trace[2]}, 32'd2);
      chk("map_hi_addr", {14'b0, trace[3]}, 32'd3);
      chk("map_hi_addr2", {14'b0, trace[4]}, 32'd3);

      preload(0, 4, 16'hFFFF);
      preload(0, 5, 16'hFFFF);
      q0.push_back('{5, 32'h1234_5678});
      xact(1, 1, 32'd1032, 32'h0000_CAFE, 1);
      chk("both_lo", {16'b0, m0[4]}, 32'h0000_CAFE);
      chk("both_hi", {16'b0, m0[5]}, 32'h0000_0000);

      q0.push_back('{5, 32'h1234_5678});
      xact(1, 0, 32'd1036, 32'hA5A5_5A5A, 0);
      chk("drop_lo", {16'b0, m0[6]}, 32'h0000_5A5A);
      chk("drop_hi", {16'b0, m0[7]}, 32'h0000_A5A5);

      // Reset in the second LO cycle of a write: low half already strobed, high half never.
      preload(0, 8, 16'h0000);
      preload(0, 9, 16'h0000);
      @(posedge clk); #1;
      wr_en = 1'b1; address = 32'd1040; write_data = 32'h1111_2222;
      @(posedge clk); #1;
      wr_en = 1'b0;
      @(posedge clk); #3;
      sram_oe = 1'b0; rst = 1'b0; #1;
      chk("arst_we_n", {31'b0, we_n}, 32'd1);
      chk("arst_dq_z", {31'b0, dq === 16'hzzzz}, 32'd1);
      chk("arst_addr", {14'b0, sa}, 32'd0);
      chk("arst_ready", {31'b0, ready}, 32'd1);
      chk("arst_rdata", read_data, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; sram_oe = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_ready", {31'b0, ready}, 32'd1);
      chk("post_rst_we_n", {31'b0, we_n}, 32'd1);
      chk("post_rst_rdata", read_data, 32'd0);
      chk("arst_lo_written", {16'b0, m0[8]}, 32'h0000_2222);
      chk("arst_hi_unwritten", {16'b0, m0[9]}, 32'h0000_0000);
      q0.push_back('{5, 32'h0000_2222});
      xact(0, 1, 32'd1040, 32'h0, 0);

      preload(1, 0, 16'h1111);
      preload(1, 1, 16'h2222);
      preload(1, 2, 16'h3333);
      preload(1, 3, 16'h4444);
      q1.push_back('{3, 32'h2222_1111});
      q1.push_back('{3, 32'h4444_3333});
      @(posedge clk); #1;
      rd_en1 = 1'b1; address1 = 32'd1024;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (ready1) break;
      end
      if (!ready1) begin
         checks++; errors++;
         $display("FAIL b2b_first_timeout: got ready1=0 expected ready1=1 within 10 cycles");
      end
      address1 = 32'd1028;
      n = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         n = k;
         if (ready1) break;
      end
      chk("b2b_done_spacing", 32'(n), 32'd4);
      @(posedge clk); #1;
      rd_en1 = 1'b0;

      repeat (4) @(negedge clk);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
# sram_controller

Bridges the pipeline memory stage to the external 16-bit SRAM: accepts one 32-bit word read or write per transaction and performs two 16-bit SRAM accesses, low half first and then high half. Sits between the MEM stage and the SRAM device. It drives the SRAM address and write strobe, owns the bidirectional SRAM data bus, and holds `ready` low to freeze the pipeline while a transaction is in flight.

## Interface
Parameters:
- WAIT_CYCLES, 2: cycles spent on each 16-bit half access; legal values are 1 or more.
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- wr_en  input  1  32-bit write request from the MEM stage.
- rd_en  input  1  32-bit read request from the MEM stage.
- address  input  32  byte address of the request.
- write_data  input  32  data to write.
- read_data  output  32  last completed read word.
- ready  output  1  0 = stall the pipeline; 1 = no transaction pending, or transaction completing this cycle.
- SRAM_WE_N  output  1  SRAM write strobe, active-low.
- SRAM_ADDR  output  18  SRAM half-word address.
- SRAM_DQ  inout  16  SRAM data bus.

## Operation
- Word address: wa = (address − BASE_ADDR) >> 2, truncated to 17 bits. Address bits [1:0] are ignored.
- The low half uses SRAM_ADDR = {wa, 1'b0}. The high half uses SRAM_ADDR = {wa, 1'b1}.
- States are IDLE, LO, HI and DONE.
  - IDLE → LO when (wr_en | rd_en) at the clock edge. On the same edge, latch wa, write_data and op (write if wr_en, else read). Write has priority when both enables are high.
  - LO → HI after WAIT_CYCLES cycles, counted by a wait counter that is reset on each state entry.
  - HI → DONE after WAIT_CYCLES cycles.
  - DONE → IDLE unconditionally. A request present in IDLE on the next cycle is treated as a new transaction.
- Once latched, the transaction runs to completion even if wr_en, rd_en or address change or drop.
- Outputs by state:
  - SRAM_WE_N = 0 only in LO or HI with a latched write; 1 otherwise.
  - SRAM_DQ is driven with write_data[15:0] in LO and write_data[31:16] in HI only while SRAM_WE_N = 0; it is high-Z otherwise.
  - SRAM_ADDR is as defined above in LO and HI, and 0 in IDLE and DONE.
- Reads: the controller samples SRAM_DQ on the last cycle of LO into read_data[15:0], and on the last cycle of HI into read_data[31:16]. read_data holds its value until the next read completes; writes do not change it.
- ready (combinational) = 1 in DONE, 1 in IDLE when no enable is high, 0 otherwise.
- Reset (rst = 0, applied at any time including mid-transaction) immediately forces:
  - state = IDLE, counter = 0, read_data = 0;
  - SRAM_WE_N = 1, SRAM_ADDR = 0, SRAM_DQ high-Z;
  - ready = 1, or 0 if an enable is high.
  - A partially written word is abandoned. No retry is made after reset.

## Timing
- Cycle 0 is the cycle in which a request is visible in IDLE; ready is 0 in that cycle.
- LO occupies cycles 1..W and HI occupies cycles W+1..2W, where W = WAIT_CYCLES.
- DONE is cycle 2W+1, with ready = 1. Total stall is 2W+1 cycles (5 with the default W).
- read_data is valid from cycle 2W+1 onward.
- The SRAM samples write data on the rising edges at which SRAM_WE_N = 0. Repeated writes of the same value within a phase are intended behaviour.
- The minimum spacing between transactions is 2W+2 cycles.

## Test plan
- Write then read, W=2: write 0xDEADBEEF at address 1024, then read 1024.
  - SRAM[0] = 0xBEEF and SRAM[1] = 0xDEAD.
  - ready is low for exactly 5 cycles per transaction.
  - After the read, read_data = 0xDEADBEEF in the read's DONE cycle.
- Address mapping: preload SRAM[2] = 0x5678 and SRAM[3] = 0x1234, then read address 1031.
  - read_data = 0x12345678, because bits [1:0] are ignored.
  - SRAM_ADDR shows 2 during LO and 3 during HI.
- Simultaneous enables: wr_en = rd_en = 1 with write_data = 0x0000CAFE at address 1032.
  - A write occurs: SRAM[4] = 0xCAFE and SRAM[5] = 0x0000.
  - read_data is unchanged.
- Request dropped mid-transaction: assert wr_en for one cycle only.
  - Both halves are still written.
  - ready stays low until DONE.
- Asynchronous reset during LO of a write: pull rst low between clock edges.
  - SRAM_WE_N goes to 1 and SRAM_DQ goes high-Z before the next edge.
  - After release, state is IDLE, read_data = 0, and the high half is unwritten.
- WAIT_CYCLES = 1 with back-to-back reads at 1024 and 1028:
  - each read stalls for 3 cycles;
  - the second read starts in the cycle after DONE;
  - both words are returned correctly.
